mdu_control: RTL

Sequencer for the multi-cycle multiply/divide unit and its HI/LO accumulator in the execute stage.
- Decodes MDU instructions presented by EX and starts the iterative datapath.
- Counts the iterations, then generates the HI/LO write strobe.
- Raises a pipeline stall when an instruction depends on HI/LO or needs the MDU while it is busy.

---
 rtl/mdu_control.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_control.sv
// mdu_control: decode/sequence control for the iterative multiply/divide unit and HI/LO writeback.
// Divide support (DIV/DIVU) is compiled in only when MDU_DIV_EN is defined.
module mdu_control #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Valid,
  input  logic       Flush,
  input  logic       MULOp,
  input  logic       ALUOp,
  input  logic [5:0] Func,
  input  logic       DivisorZero,
  output logic       Stall,
  output logic       Init,
  output logic       IterEn,
  output logic [5:0] Count,
  output logic       AccWrite,
  output logic [1:0] AccSel,
  output logic       Signed,
  output logic [1:0] Accum,
  output logic       IsDiv,
  output logic       Done,
  output logic       Busy
);

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MDU_DIV_EN
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;

  typedef enum logic [1:0] {IDLE, ITER, WB} state_t;

  state_t      state;
  logic        mul_q;   // MUL in flight: GPR result pending, keep the pipe stalled
  logic        mul_ex;  // EX still holds the MUL that was accepted; do not re-issue it
  logic        dz_q;    // divide by zero: skip the HI/LO write
  logic        live;
  logic        dec_hilo, dec_mthi, dec_mtlo, dec_start, dec_mul, dec_div, dec_signed;
  logic [1:0]  dec_accum;

  assign live = Valid & ~Flush & ~mul_ex & ~rst;

  // Instruction decode of the live EX slot
  always_comb begin
    dec_hilo   = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_start  = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_accum  = 2'b00;
    if (live) begin
      if (ALUOp) begin
        case (Func)
          F_MFHI, F_MFLO: dec_hilo = 1'b1;
          F_MTHI:  begin dec_hilo = 1'b1; dec_mthi = 1'b1; end
          F_MTLO:  begin dec_hilo = 1'b1; dec_mtlo = 1'b1; end
          F_MULT:  begin dec_start = 1'b1; dec_signed = 1'b1; end
          F_MULTU: dec_start = 1'b1;
`ifdef MDU_DIV_EN
          F_DIV:   begin dec_start = 1'b1; dec_div = 1'b1; dec_signed = 1'b1; end
          F_DIVU:  begin dec_start = 1'b1; dec_div = 1'b1; end
`endif
          default: ;
        endcase
      end else if (MULOp) begin
        case (Func)
          F_MADD:  begin dec_start = 1'b1; dec_signed = 1'b1; dec_accum = 2'b01; end
          F_MADDU: begin dec_start = 1'b1; dec_accum = 2'b01; end
          F_MUL:   begin dec_start = 1'b1; dec_signed = 1'b1; dec_mul = 1'b1; end
          F_MSUB:  begin dec_start = 1'b1; dec_signed = 1'b1; dec_accum = 2'b10; end
          F_MSUBU: begin dec_start = 1'b1; dec_accum = 2'b10; end
          default: ;
        endcase
      end
    end
  end

  // Same-cycle handshake outputs: stall, operand load and HI/LO write strobe
  always_comb begin
    Stall    = 1'b0;
    Init     = 1'b0;
    AccWrite = 1'b0;
    AccSel   = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (dec_start) begin
            Init  = 1'b1;
            Stall = dec_mul;
          end else if (dec_mthi) begin
            AccWrite = 1'b1;
            AccSel   = 2'b01;
          end else if (dec_mtlo) begin
            AccWrite = 1'b1;
            AccSel   = 2'b10;
          end
        end
        ITER: Stall = mul_q | dec_hilo | dec_start;
        WB: begin
          Stall    = mul_q | dec_hilo | dec_start;
          AccWrite = ~dz_q;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Count  <= '0;
      IterEn <= 1'b0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      Signed <= 1'b0;
      Accum  <= 2'b00;
      IsDiv  <= 1'b0;
      mul_q  <= 1'b0;
      mul_ex <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      if (Flush) mul_ex <= 1'b0;
      case (state)
        IDLE: begin
          if (dec_start) begin
            Signed <= dec_signed;
            Accum  <= dec_accum;
            IsDiv  <= dec_div;
            mul_q  <= dec_mul;
            mul_ex <= dec_mul;
            dz_q   <= dec_div & DivisorZero;
            Busy   <= 1'b1;
            if (dec_div && DivisorZero) begin
              state <= WB;
              Count <= '0;
              Done  <= 1'b1;
            end else begin
              state  <= ITER;
              Count  <= dec_div ? DIV_LAST : MUL_LAST;
              IterEn <= 1'b1;
            end
          end else begin
            mul_ex <= 1'b0;
          end
        end
        ITER: begin
          if (Count == '0) begin
            state  <= WB;
            IterEn <= 1'b0;
            Done   <= 1'b1;
          end else begin
            Count <= Count - CW'(1);
          end
        end
        WB: begin
          state <= IDLE;
          Done  <= 1'b0;
          Busy  <= 1'b0;
          mul_q <= 1'b0;
          dz_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
